traffic_light_ctrl_param: RTL and testbench

Parametrised single-intersection traffic-light controller, successor to the fixed-timing four-phase light FSM. Generates its own one-cycle seconds enable from the system clock and sequences RED → YELLOW1 → GREEN → YELLOW2 with per-phase durations set by parameters. Adds a pedestrian request handshake that shortens GREEN, and a night mode that flashes yellow. Sits between the board clock/reset and the lamp/display top module.

---
 rtl/traffic_light_ctrl_param.sv | 209 ++++++++++++++++++++
 tb/tb_traffic_light_ctrl_param.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl_param.sv
// traffic_light_ctrl_param: single-intersection traffic-light controller.
// Derives a one-cycle phase tick from the system clock and sequences
// RED -> YELLOW1 -> GREEN -> YELLOW2 with parameterised per-phase durations.
// A latched pedestrian request may cut GREEN short once its minimum time has
// elapsed; night mode overrides everything with a flashing yellow.
// Optional feature macro: PED_REQ_EN
//   defined   - pedestrian request/acknowledge handshake and early GREEN end.
//   undefined - ped_req ignored, ped_ack held low, GREEN always runs T_GREEN.
module traffic_light_ctrl_param #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned T_RED       = 40,
    parameter int unsigned T_YELLOW    = 3,
    parameter int unsigned T_GREEN     = 21,
    parameter int unsigned T_GREEN_MIN = 5,
    parameter int unsigned CNT_W       = 6
) (
    input  logic       clk_50MHz,
    input  logic       res,
    input  logic       ped_req,
    input  logic       night,
    output logic [2:0] out_state,
    output logic [2:0] lamps,
    output logic       ped_walk,
    output logic       ped_ack,
    output logic       tick
);

    // Prescaler width; a divider of one still needs a one-bit register.
    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] RED_LAST  = CNT_W'(T_RED - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] GRN_LAST  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(T_GREEN_MIN - 1);

    typedef enum logic [2:0] {
        StRed      = 3'd0,
        StYellow1  = 3'd1,
        StGreen    = 3'd2,
        StYellow2  = 3'd3,
        StFlashOn  = 3'd4,
        StFlashOff = 3'd5
    } state_e;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, tick_d;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] ph_cnt_q, ph_cnt_d;
    logic [CNT_W-1:0] phase_last;
    logic             phase_done;
    logic             early_end;

    logic [2:0]       lamps_q, lamps_d;
    logic             walk_q, walk_d;

    logic             ped_pend_q, ped_pend_d;
    logic             ped_ack_q;
    logic             ped_set;
    logic             clr_pend;

    // Prescaler next value and tick decode; the tick register then lines up
    // with the cycle in which the prescaler sits at TICK_DIV-1.
    always_comb begin
        pre_d  = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
        tick_d = (pre_d == PRE_MAX);
    end

    // Free-running prescaler and registered tick, never disturbed by the FSM.
    always_ff @(posedge clk_50MHz or posedge res) begin
        if (res) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    // Last phase-counter value of the current timed state.
    always_comb begin
        unique case (state_q)
            StRed:                phase_last = RED_LAST;
            StYellow1, StYellow2: phase_last = YEL_LAST;
            StGreen:              phase_last = GRN_LAST;
            default:              phase_last = '0;
        endcase
    end

    assign phase_done = (ph_cnt_q == phase_last);
    // Only meaningful in GREEN; ped_pend_q is constant zero without PED_REQ_EN.
    assign early_end  = ped_pend_q && (ph_cnt_q >= GMIN_LAST);

    // Next state, evaluated on tick only: night beats pedestrian beats timeout.
    always_comb begin
        state_d = state_q;
        if (tick_q) begin
            unique case (state_q)
                StRed: begin
                    if (night) begin
                        state_d = StFlashOn;
                    end else if (phase_done) begin
                        state_d = StYellow1;
                    end
                end
                StYellow1: begin
                    if (night) begin
                        state_d = StFlashOn;
                    end else if (phase_done) begin
                        state_d = StGreen;
                    end
                end
                StGreen: begin
                    if (night) begin
                        state_d = StFlashOn;
                    end else if (early_end || phase_done) begin
                        state_d = StYellow2;
                    end
                end
                StYellow2: begin
                    if (night) begin
                        state_d = StFlashOn;
                    end else if (phase_done) begin
                        state_d = StRed;
                    end
                end
                StFlashOn:  state_d = night ? StFlashOff : StRed;
                StFlashOff: state_d = night ? StFlashOn : StRed;
                default:    state_d = StRed;
            endcase
        end
    end

    // Phase counter restarts on every state change, otherwise counts ticks.
    always_comb begin
        ph_cnt_d = ph_cnt_q;
        if (state_d != state_q) begin
            ph_cnt_d = '0;
        end else if (tick_q) begin
            ph_cnt_d = ph_cnt_q + 1'b1;
        end
    end

    // Lamp and walk decode from the upcoming state so both leave a register.
    always_comb begin
        lamps_d = 3'b100;
        walk_d  = (state_d == StRed);
        unique case (state_d)
            StRed:      lamps_d = 3'b100;
            StYellow1:  lamps_d = 3'b110;
            StGreen:    lamps_d = 3'b001;
            StYellow2:  lamps_d = 3'b010;
            StFlashOn:  lamps_d = 3'b010;
            StFlashOff: lamps_d = 3'b000;
            default:    lamps_d = 3'b100;
        endcase
    end

    // Entering RED or a flash state drops any pending request.
    assign clr_pend = (state_d == StRed) || (state_d == StFlashOn) ||
                      (state_d == StFlashOff);

`ifdef PED_REQ_EN
    // Latch a fresh request while traffic moves; a request that coincides with
    // entering RED or flash is dropped and therefore not acknowledged.
    always_comb begin
        ped_set    = ped_req && !ped_pend_q && !clr_pend &&
                     ((state_q == StYellow1) || (state_q == StGreen) ||
                      (state_q == StYellow2));
        ped_pend_d = clr_pend ? 1'b0 : (ped_pend_q || ped_set);
    end
`else
    logic unused_ped;
    assign unused_ped = ped_req | clr_pend;

    // Pedestrian handshake compiled out: nothing ever latches or acknowledges.
    always_comb begin
        ped_set    = 1'b0;
        ped_pend_d = 1'b0;
    end
`endif

    // FSM state, phase counter, decoded outputs and pedestrian handshake.
    always_ff @(posedge clk_50MHz or posedge res) begin
        if (res) begin
            state_q    <= StRed;
            ph_cnt_q   <= '0;
            lamps_q    <= 3'b100;
            walk_q     <= 1'b1;
            ped_pend_q <= 1'b0;
            ped_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_cnt_q   <= ph_cnt_d;
            lamps_q    <= lamps_d;
            walk_q     <= walk_d;
            ped_pend_q <= ped_pend_d;
            ped_ack_q  <= ped_set;
        end
    end

    assign out_state = state_q;
    assign lamps     = lamps_q;
    assign ped_walk  = walk_q;
    assign ped_ack   = ped_ack_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Bench for traffic_light_ctrl_param: directed vector table, hand-written
// pedestrian/night/reset sequences and random stimulus, all compared against
// a phase-level reference model (ticks elapsed in state vs. phase duration).
module tb_traffic_light_ctrl_param;

    localparam int unsigned TD  = 4;
    localparam int unsigned TR  = 5;
    localparam int unsigned TY  = 2;
    localparam int unsigned TG  = 6;
    localparam int unsigned TGM = 2;
    localparam int unsigned CW  = 3;

`ifdef PED_REQ_EN
    localparam bit PED_ON = 1'b1;
`else
    localparam bit PED_ON = 1'b0;
`endif

    localparam int RED = 0, Y1 = 1, GRN = 2, Y2 = 3, FON = 4, FOFF = 5;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       ped_req = 1'b0;
    logic       night = 1'b0;
    logic [2:0] out_state;
    logic [2:0] lamps;
    logic       ped_walk;
    logic       ped_ack;
    logic       tick;

    int errors = 0;
    int checks = 0;

    traffic_light_ctrl_param #(
        .TICK_DIV    (TD),
        .T_RED       (TR),
        .T_YELLOW    (TY),
        .T_GREEN     (TG),
        .T_GREEN_MIN (TGM),
        .CNT_W       (CW)
    ) dut (
        .clk_50MHz (clk),
        .res       (res),
        .ped_req   (ped_req),
        .night     (night),
        .out_state (out_state),
        .lamps     (lamps),
        .ped_walk  (ped_walk),
        .ped_ack   (ped_ack),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    int m_edges;
    bit m_tick;
    int m_st;
    int m_el;
    bit m_pend;
    bit m_ack;

    function automatic int dur(input int s);
        case (s)
            RED:     return TR;
            Y1, Y2:  return TY;
            GRN:     return TG;
            default: return 1;
        endcase
    endfunction

    function automatic logic [2:0] lamp_of(input int s);
        case (s)
            RED:     return 3'b100;
            Y1:      return 3'b110;
            GRN:     return 3'b001;
            Y2:      return 3'b010;
            FON:     return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit is_flash(input int s);
        return (s == FON) || (s == FOFF);
    endfunction

    task automatic model_reset();
        m_edges = 0;
        m_tick  = 1'b0;
        m_st    = RED;
        m_el    = 0;
        m_pend  = 1'b0;
        m_ack   = 1'b0;
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_step();
        int nxt;
        bit tk;
        bit set;
        tk  = m_tick;
        nxt = m_st;
        if (tk) begin
            if (is_flash(m_st)) nxt = night ? ((m_st == FON) ? FOFF : FON) : RED;
            else if (night) nxt = FON;
            else if (PED_ON && m_st == GRN && m_pend && (m_el + 1 >= int'(TGM))) nxt = Y2;
            else if (m_el + 1 == dur(m_st)) nxt = (m_st + 1) % 4;
        end
        set = PED_ON && ped_req && !m_pend && (m_st == Y1 || m_st == GRN || m_st == Y2);
        if (nxt == RED || is_flash(nxt)) begin
            m_pend = 1'b0;
            m_ack  = 1'b0;
        end else begin
            m_ack = set;
            if (set) m_pend = 1'b1;
        end
        if (nxt != m_st) m_el = 0;
        else if (tk) m_el = m_el + 1;
        m_st    = nxt;
        m_edges = m_edges + 1;
        m_tick  = ((m_edges % TD) == TD - 1);
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".state"}, 32'(out_state), 32'(m_st));
        chk({tag, ".lamps"}, 32'(lamps), 32'(lamp_of(m_st)));
        chk({tag, ".walk"}, 32'(ped_walk), 32'(m_st == RED));
        chk({tag, ".ack"}, 32'(ped_ack), 32'(m_ack));
        chk({tag, ".tick"}, 32'(tick), 32'(m_tick));
    endtask

    // Called at a negedge with inputs set: one clock edge, then compare.
    task automatic cycle();
        model_step();
        @(negedge clk);
        compare_model("model");
    endtask

    // Called at a negedge; checks reset values before any clock edge.
    task automatic do_reset();
        #2 res = 1'b1;
        #1;
        chk("rst.state", 32'(out_state), 32'(RED));
        chk("rst.lamps", 32'(lamps), 32'(3'b100));
        chk("rst.walk", 32'(ped_walk), 32'd1);
        chk("rst.ack", 32'(ped_ack), 32'd0);
        chk("rst.tick", 32'(tick), 32'd0);
        model_reset();
        @(negedge clk);
        res     = 1'b0;
        ped_req = 1'b0;
        night   = 1'b0;
        compare_model("rst");
    endtask

    task automatic wait_for(input int target, input int budget);
        int n;
        n = 0;
        while (out_state !== 3'(target) && n < budget) begin
            cycle();
            n++;
        end
        chk("wait_for_state", 32'(out_state), 32'(target));
    endtask

    task automatic hold_len(input int target, input int budget, output int n);
        n = 0;
        while (out_state === 3'(target) && n < budget) begin
            n++;
            cycle();
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         nt;
        int         cycles;
        logic [2:0] st;
        logic [2:0] lmp;
        bit         walk;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int n;
        int acks;

        vecs[0]  = '{1'b0, 19, 3'd0, 3'b100, 1'b1};
        vecs[1]  = '{1'b0, 8,  3'd1, 3'b110, 1'b0};
        vecs[2]  = '{1'b0, 24, 3'd2, 3'b001, 1'b0};
        vecs[3]  = '{1'b0, 8,  3'd3, 3'b010, 1'b0};
        vecs[4]  = '{1'b0, 20, 3'd0, 3'b100, 1'b1};
        vecs[5]  = '{1'b0, 8,  3'd1, 3'b110, 1'b0};
        vecs[6]  = '{1'b0, 10, 3'd2, 3'b001, 1'b0};
        vecs[7]  = '{1'b1, 2,  3'd2, 3'b001, 1'b0};
        vecs[8]  = '{1'b1, 4,  3'd4, 3'b010, 1'b0};
        vecs[9]  = '{1'b1, 4,  3'd5, 3'b000, 1'b0};
        vecs[10] = '{1'b1, 4,  3'd4, 3'b010, 1'b0};
        vecs[11] = '{1'b0, 20, 3'd0, 3'b100, 1'b1};
        vecs[12] = '{1'b0, 8,  3'd1, 3'b110, 1'b0};

        @(negedge clk);
        do_reset();

        // Idle sequence, then night entered mid-GREEN and left again.
        for (int i = 0; i < 13; i++) begin
            night = vecs[i].nt;
            for (int j = 0; j < vecs[i].cycles; j++) begin
                cycle();
                chk($sformatf("vec%0d.state", i), 32'(out_state), 32'(vecs[i].st));
                chk($sformatf("vec%0d.lamps", i), 32'(lamps), 32'(vecs[i].lmp));
                chk($sformatf("vec%0d.walk", i), 32'(ped_walk), 32'(vecs[i].walk));
            end
        end
        night = 1'b0;

        // Request pulse at GREEN entry shortens GREEN to T_GREEN_MIN ticks.
        do_reset();
        wait_for(GRN, 200);
        ped_req = 1'b1;
        cycle();
        ped_req = 1'b0;
        chk("ped_ack_pulse", 32'(ped_ack), 32'(PED_ON));
        cycle();
        chk("ped_ack_one_cycle", 32'(ped_ack), 32'd0);
        hold_len(GRN, 100, n);
        chk("green_len_ped", 32'(n + 2), PED_ON ? 32'd8 : 32'd24);
        hold_len(Y2, 100, n);
        chk("y2_len_ped", 32'(n), 32'd8);
        chk("red_state_ped", 32'(out_state), 32'(RED));
        chk("red_walk_ped", 32'(ped_walk), 32'd1);
        wait_for(GRN, 200);
        hold_len(GRN, 100, n);
        chk("green_len_after_clear", 32'(n), 32'd24);

        // Request held high: a single acknowledge per traffic cycle.
        do_reset();
        wait_for(Y1, 200);
        ped_req = 1'b1;
        acks = 0;
        n = 0;
        while (out_state !== 3'(RED) && n < 200) begin
            cycle();
            acks += int'(ped_ack);
            n++;
        end
        ped_req = 1'b0;
        chk("held_ack_count", 32'(acks), 32'(PED_ON));

        // Request during RED is ignored.
        do_reset();
        cycle();
        ped_req = 1'b1;
        cycle();
        ped_req = 1'b0;
        chk("red_req_no_ack", 32'(ped_ack), 32'd0);
        cycle();
        chk("red_req_no_ack2", 32'(ped_ack), 32'd0);
        wait_for(GRN, 200);
        hold_len(GRN, 100, n);
        chk("green_len_red_req", 32'(n), 32'd24);

        // Request during flashing is ignored; leaving night gives a full RED.
        night = 1'b1;
        wait_for(FON, 50);
        ped_req = 1'b1;
        cycle();
        ped_req = 1'b0;
        chk("flash_req_no_ack", 32'(ped_ack), 32'd0);
        night = 1'b0;
        wait_for(RED, 50);
        hold_len(RED, 100, n);
        chk("red_len_after_night", 32'(n), 32'd20);

        // Asynchronous reset mid-YELLOW2 while an acknowledge is showing.
        wait_for(Y2, 200);
        cycle();
        ped_req = 1'b1;
        cycle();
        ped_req = 1'b0;
        chk("ack_before_reset", 32'(ped_ack), 32'(PED_ON));
        do_reset();

        // Random requests and night toggles against the model.
        for (int k = 0; k < 3000; k++) begin
            ped_req = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) night = ~night;
            cycle();
        end
        ped_req = 1'b0;
        night   = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
